// File: rtl/pc_select_bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_select_bpu_pkg
// Brief    : Shared constants and counter helper for the fetch PC selector/BTB.
// Revision : 1.0 - initial release
// ============================================================================
package pc_select_bpu_pkg;

    // 2-bit saturating direction counter encodings
    localparam logic [1:0] c_ctr_snt = 2'b00;
    localparam logic [1:0] c_ctr_wnt = 2'b01;
    localparam logic [1:0] c_ctr_wt  = 2'b10;
    localparam logic [1:0] c_ctr_st  = 2'b11;

    localparam logic [31:0] c_reset_pc   = 32'h8000_0000;
    localparam int          c_inst_bytes = 4;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == c_ctr_st) ? c_ctr_st : ctr + 2'b01;
        end
        return (ctr == c_ctr_snt) ? c_ctr_snt : ctr - 2'b01;
    endfunction

endpackage : pc_select_bpu_pkg
`default_nettype wire

// File: rtl/pc_select_bpu_btb_table.sv
`default_nettype none
// ============================================================================
// Module   : pc_select_bpu_btb_table
// Brief    : Direct-mapped BTB with 2-bit counters; async read, sync train.
// Revision : 1.0 - initial release
// ============================================================================
module pc_select_bpu_btb_table
    import pc_select_bpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_rd_pc,
    output logic            o_rd_hit,
    output logic            o_rd_taken,
    output logic [XLEN-1:0] o_rd_target,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic            i_wr_taken,
    input  logic [XLEN-1:0] i_wr_target
);

    localparam int c_idx_w = $clog2(BTB_ENTRIES);
    localparam int c_tag_w = XLEN - c_idx_w - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [1:0]             r_ctr    [BTB_ENTRIES];
    logic [c_tag_w-1:0]     r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];

    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_tag_w-1:0] w_rd_tag;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_tag_w-1:0] w_wr_tag;
    logic               w_wr_hit;
    logic               w_unused_lsbs;

    assign w_rd_idx = i_rd_pc[c_idx_w+1:2];
    assign w_rd_tag = i_rd_pc[XLEN-1:c_idx_w+2];
    assign w_wr_idx = i_wr_pc[c_idx_w+1:2];
    assign w_wr_tag = i_wr_pc[XLEN-1:c_idx_w+2];
    // Instruction-aligned PCs: the two byte-offset bits never matter
    assign w_unused_lsbs = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

    assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_taken  = o_rd_hit && r_ctr[w_rd_idx][1];
    assign o_rd_target = r_target[w_rd_idx];
    assign w_wr_hit    = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_ctr[i] <= c_ctr_wnt;
            end
        end else if (i_wr_en) begin
            if (w_wr_hit) begin
                r_ctr[w_wr_idx] <= ctr_next(r_ctr[w_wr_idx], i_wr_taken);
            end else if (i_wr_taken) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_ctr[w_wr_idx]   <= c_ctr_wt;
            end
        end
    end

    // Tag/target carry no reset; rewriting the tag on a taken hit is a no-op
    always_ff @(posedge clk) begin
        if (!rst && i_wr_en && i_wr_taken) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= i_wr_target;
        end
    end

endmodule : pc_select_bpu_btb_table
`default_nettype wire

// File: rtl/pc_select_bpu.sv
`default_nettype none
// ============================================================================
// Module   : pc_select_bpu
// Brief    : Fetch PC register and next-PC select (redirect > stall > BTB > +4).
// Revision : 1.0 - initial release
// ============================================================================
module pc_select_bpu
    import pc_select_bpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(c_reset_pc)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            execute_redirect_i,
    input  logic [XLEN-1:0] execute_next_pc_i,
    input  logic            execute_update_i,
    input  logic [XLEN-1:0] execute_pc_i,
    input  logic            execute_taken_i,
    input  logic [XLEN-1:0] execute_target_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            predict_taken_o,
    output logic [XLEN-1:0] predict_target_o,
    output logic            btb_hit_o
);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_btb_target;
    logic            w_hit;
    logic            w_taken;

    pc_select_bpu_btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_pc     (r_fetch_pc),
        .o_rd_hit    (w_hit),
        .o_rd_taken  (w_taken),
        .o_rd_target (w_btb_target),
        .i_wr_en     (execute_update_i),
        .i_wr_pc     (execute_pc_i),
        .i_wr_taken  (execute_taken_i),
        .i_wr_target (execute_target_i)
    );

    assign w_seq_pc = r_fetch_pc + XLEN'(c_inst_bytes);

    always_comb begin
        w_next_pc = w_seq_pc;
        if (execute_redirect_i) begin
            w_next_pc = execute_next_pc_i;
        end else if (stall_i) begin
            w_next_pc = r_fetch_pc;
        end else if (w_taken) begin
            w_next_pc = w_btb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= w_next_pc;
        end
    end

    assign fetch_pc_o       = r_fetch_pc;
    assign btb_hit_o        = w_hit;
    assign predict_taken_o  = w_taken;
    assign predict_target_o = w_hit ? w_btb_target : w_seq_pc;

endmodule : pc_select_bpu
`default_nettype wire

// File: tb/tb_pc_select_bpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_select_bpu
// Brief    : Scoreboard bench for pc_select_bpu against a behavioural BTB model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_select_bpu;

    localparam logic [31:0] c_rst_pc = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        execute_redirect_i;
    logic [31:0] execute_next_pc_i;
    logic        execute_update_i;
    logic [31:0] execute_pc_i;
    logic        execute_taken_i;
    logic [31:0] execute_target_i;
    logic [31:0] fetch_pc_o;
    logic        predict_taken_o;
    logic [31:0] predict_target_o;
    logic        btb_hit_o;

    always #5 clk = ~clk;

    pc_select_bpu dut (
        .clk                (clk),
        .rst                (rst),
        .stall_i            (stall_i),
        .execute_redirect_i (execute_redirect_i),
        .execute_next_pc_i  (execute_next_pc_i),
        .execute_update_i   (execute_update_i),
        .execute_pc_i       (execute_pc_i),
        .execute_taken_i    (execute_taken_i),
        .execute_target_i   (execute_target_i),
        .fetch_pc_o         (fetch_pc_o),
        .predict_taken_o    (predict_taken_o),
        .predict_target_o   (predict_target_o),
        .btb_hit_o          (btb_hit_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural reference: 16 entries, index pc[5:2], tag pc[31:6]
    logic [31:0] m_pc = '0;
    logic [15:0] m_valid = '0;
    logic [1:0]  m_ctr [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] npc,
                         input logic up, input logic [31:0] upc, input logic tk,
                         input logic [31:0] utg);
        logic [3:0] li;
        logic [3:0] ui;
        logic       lhit;
        logic       uhit;
        exp_t       e;
        exp_t       got;

        rst = r; stall_i = st; execute_redirect_i = rd; execute_next_pc_i = npc;
        execute_update_i = up; execute_pc_i = upc; execute_taken_i = tk; execute_target_i = utg;

        li   = m_pc[5:2];
        lhit = m_valid[li] && (m_tag[li] == m_pc[31:6]);
        if (r) begin
            m_pc    = c_rst_pc;
            m_valid = '0;
            for (int i = 0; i < 16; i++) m_ctr[i] = 2'b01;
        end else begin
            if (rd)                           m_pc = npc;
            else if (st)                      m_pc = m_pc;
            else if (lhit && m_ctr[li][1])    m_pc = m_tgt[li];
            else                              m_pc = m_pc + 32'd4;
            if (up) begin
                ui   = upc[5:2];
                uhit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
                if (uhit && tk) begin
                    if (m_ctr[ui] != 2'b11) m_ctr[ui] = m_ctr[ui] + 2'b01;
                    m_tgt[ui] = utg;
                end else if (uhit) begin
                    if (m_ctr[ui] != 2'b00) m_ctr[ui] = m_ctr[ui] - 2'b01;
                end else if (tk) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = upc[31:6];
                    m_tgt[ui]   = utg;
                    m_ctr[ui]   = 2'b10;
                end
            end
        end

        li      = m_pc[5:2];
        e.pc    = m_pc;
        e.hit   = m_valid[li] && (m_tag[li] == m_pc[31:6]);
        e.taken = e.hit && m_ctr[li][1];
        e.tgt   = e.hit ? m_tgt[li] : m_pc + 32'd4;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            got.pc = fetch_pc_o; got.hit = btb_hit_o;
            got.taken = predict_taken_o; got.tgt = predict_target_o;
            check_eq("fetch_pc", got.pc, e.pc);
            check_eq("btb_hit", {31'd0, got.hit}, {31'd0, e.hit});
            check_eq("pred_taken", {31'd0, got.taken}, {31'd0, e.taken});
            check_eq("pred_target", got.tgt, e.tgt);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic redir(input logic [31:0] pc);
        drive(0, 0, 1, pc, 0, '0, 0, '0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        drive(0, 0, 0, '0, 1, pc, tk, tgt);
    endtask

    initial begin
        // Reset, then sequential fetch from RESET_PC
        drive(1, 0, 0, '0, 0, '0, 0, '0);
        drive(1, 0, 0, '0, 0, '0, 0, '0);
        idle(4);
        // Stall holds; redirect wins over stall
        drive(0, 1, 0, '0, 0, '0, 0, '0);
        drive(0, 1, 0, '0, 0, '0, 0, '0);
        drive(0, 1, 1, 32'h8000_0200, 0, '0, 0, '0);
        // Allocate, then fetch through the trained PC
        upd(32'h8000_0040, 1, 32'h8000_0100);
        redir(32'h8000_0038);
        idle(3);
        // Drive the counter down to saturation at 00
        for (int k = 0; k < 3; k++) upd(32'h8000_0040, 0, 32'h0);
        redir(32'h8000_0040);
        idle(1);
        // Drive it up to 11; one not-taken must still predict taken
        for (int k = 0; k < 4; k++) upd(32'h8000_0040, 1, 32'h8000_0100);
        upd(32'h8000_0040, 0, 32'h0);
        redir(32'h8000_0040);
        idle(1);
        // Aliasing on index 0
        upd(32'h8000_0080, 1, 32'h8000_0300);
        redir(32'h8000_0040);
        redir(32'h8000_0080);
        // Same-cycle update and lookup while stalled
        drive(0, 1, 0, '0, 1, 32'h8000_0080, 1, 32'h8000_0400);
        idle(1);
        // Update concurrent with redirect
        drive(0, 0, 1, 32'h8000_0080, 1, 32'h8000_0080, 0, '0);
        // Wraparound of the sequential PC
        redir(32'hFFFF_FFFC);
        idle(2);
        // Mid-run reset drops a concurrent update and clears all hits
        drive(1, 0, 0, '0, 1, 32'h8000_0080, 1, 32'h8000_0500);
        redir(32'h8000_0080);
        redir(32'h8000_0040);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_select_bpu
`default_nettype wire
